robo_sequenciador: RTL and testbench
====================================

ROBO_SEQUENCIADOR -- requirements
Module: robo_sequenciador

Interface
REQ-001 Parameter TICK_DIV, default 2, clock cycles per decision tick (>=2).
REQ-002 Parameter STEP_CYCLES, default 4, cycles motor_frente is held per forward step (>=1).
REQ-003 Parameter TURN_CYCLES, default 8, cycles motor_giro is held per turn step (>=1).
REQ-004 Parameter SETTLE_CYCLES, default 2, idle-motor cycles after every step (>=1).
REQ-005 clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 parada  in  1  emergency stop, level-sensitive.
REQ-008 auto_avancar, auto_girar  in  1 each  motion request from the wall-following FSM.
REQ-009 man_req  in  1  manual requester wants the actuator; held until man_gnt.
REQ-010 man_avancar, man_girar  in  1 each  manual command, valid while man_req=1.
REQ-011 auto_passo  out  1  one-cycle tick; the wall-following FSM advances state only when it is 1.
REQ-012 man_gnt  out  1  one-cycle pulse: manual command accepted.
REQ-013 motor_frente, motor_giro  out  1 each  registered actuator drives.
REQ-014 ocupado  out  1  1 whenever state is not IDLE.

Function
REQ-015 Free-running prescaler 0..TICK_DIV-1 shall assert auto_passo for one cycle when it equals TICK_DIV-1, in all states except reset.
REQ-016 States SHALL be IDLE, AVANCA, GIRA, PAUSA.
REQ-017 Arbitration occurs only in IDLE on a cycle with auto_passo=1 and parada=0.
REQ-018 Arbitration: man_req=1 wins unless the previous grant was manual and the auto command is nonzero, in which case auto wins (strict alternation under contention).
REQ-019 A manual win SHALL pulse man_gnt in the arbitration cycle and latch man_avancar/man_girar; last_grant := manual. Auto win sets last_grant := auto.
REQ-020 Latched command decode: girar=1 -> GIRA (girar has precedence over avancar); avancar=1 only -> AVANCA; both 0 -> remain IDLE, man_gnt still pulses if manual won.
REQ-021 AVANCA: motor_frente=1 for exactly STEP_CYCLES consecutive cycles starting the cycle after arbitration, then PAUSA.
REQ-022 GIRA: motor_giro=1 for exactly TURN_CYCLES consecutive cycles starting the cycle after arbitration, then PAUSA.
REQ-023 PAUSA: both motors 0 for exactly SETTLE_CYCLES cycles, then IDLE.
REQ-024 motor_frente and motor_giro SHALL never be 1 in the same cycle.
REQ-025 Inputs sampled only at arbitration; request changes during AVANCA/GIRA/PAUSA are ignored.
REQ-026 parada=1 in any state: next cycle state IDLE, both motors 0, step counter 0, no man_gnt while parada=1; prescaler keeps running.
REQ-027 Step counter width $clog2(max(STEP_CYCLES,TURN_CYCLES,SETTLE_CYCLES)+1); no wrap permitted.

Reset
REQ-028 reset=1 at a rising edge: state IDLE, prescaler 0, step counter 0, last_grant auto, all outputs 0; overrides parada and any in-progress step.

Structure
REQ-029 Package robo_pkg SHALL hold the state encoding and default values of the four parameters.
REQ-030 Prescaler SHALL be a sub-module robo_prescaler (TICK_DIV parameter, clock, reset, tick out).

Verification (TICK_DIV=2, STEP=4, TURN=8, SETTLE=2)
REQ-031 Reset, auto_avancar=1 held -> auto_passo every 2nd cycle; motor_frente high 4 cycles, low >=2, repeating; motor_giro never 1.
REQ-032 auto_avancar=1, auto_girar=1 -> motor_giro high 8 cycles, motor_frente 0 throughout.
REQ-033 man_req=1, man_girar=1 while auto_avancar=1 -> man_gnt single pulse at first IDLE tick, then motor_giro 8 cycles.
REQ-034 man_req held with man_avancar=1, auto_girar=1 -> steps alternate manual forward / auto turn; man_gnt every second step.
REQ-035 parada=1 on 3rd cycle of GIRA -> motor_giro 0 next cycle, ocupado 0; man_req pending gets no grant until parada=0.
REQ-036 reset=1 on 2nd cycle of AVANCA -> all outputs 0 after that edge; first auto_passo 2 cycles after reset release.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared types and defaults for the robot actuator sequencer.
// State encoding, grant bookkeeping and parameter defaults live here.
package robo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AVANCA = 2'd1,
    GIRA   = 2'd2,
    PAUSA  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_AUTO = 1'b0,
    GRANT_MAN  = 1'b1
  } grant_t;

  localparam int TICK_DIV_DEFAULT      = 2;
  localparam int STEP_CYCLES_DEFAULT   = 4;
  localparam int TURN_CYCLES_DEFAULT   = 8;
  localparam int SETTLE_CYCLES_DEFAULT = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/robo_sequenciador_if.sv
// Command/actuator bundle between the request sources and the sequencer.
interface robo_sequenciador_if;

  logic parada;
  logic auto_avancar;
  logic auto_girar;
  logic man_req;
  logic man_avancar;
  logic man_girar;
  logic auto_passo;
  logic man_gnt;
  logic motor_frente;
  logic motor_giro;
  logic ocupado;

  modport master (
    output parada, auto_avancar, auto_girar, man_req, man_avancar, man_girar,
    input  auto_passo, man_gnt, motor_frente, motor_giro, ocupado
  );

  modport slave (
    input  parada, auto_avancar, auto_girar, man_req, man_avancar, man_girar,
    output auto_passo, man_gnt, motor_frente, motor_giro, ocupado
  );

endinterface

// File: rtl/robo_prescaler.sv
// Free-running decision-tick prescaler: one-cycle tick when the count hits TICK_DIV-1.
module robo_prescaler
  import robo_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !reset;

endmodule

// File: rtl/robo_sequenciador.sv
// Arbitrates manual vs. wall-following requests and times forward/turn steps with a settle pause.
module robo_sequenciador
  import robo_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_DEFAULT,
  parameter int STEP_CYCLES   = STEP_CYCLES_DEFAULT,
  parameter int TURN_CYCLES   = TURN_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  robo_sequenciador_if.slave bus
);

  localparam int CNT_W = $clog2(max3(STEP_CYCLES, TURN_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  grant_t           last_grant, last_grant_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             tick, man_win, gnt;
  logic             sel_avancar, sel_girar;
  logic             motor_frente_q, motor_giro_q;

  robo_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Manual loses only when it won last time and the wall follower is asking for motion.
  assign man_win = bus.man_req &&
                   !(last_grant == GRANT_MAN && (bus.auto_avancar || bus.auto_girar));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    gnt             = 1'b0;
    sel_avancar     = 1'b0;
    sel_girar       = 1'b0;
    if (bus.parada) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick) begin
            if (man_win) begin
              gnt             = 1'b1;
              last_grant_next = GRANT_MAN;
              sel_avancar     = bus.man_avancar;
              sel_girar       = bus.man_girar;
            end else begin
              last_grant_next = GRANT_AUTO;
              sel_avancar     = bus.auto_avancar;
              sel_girar       = bus.auto_girar;
            end
            cnt_next = '0;
            if (sel_girar)        state_next = GIRA;
            else if (sel_avancar) state_next = AVANCA;
          end
        end
        AVANCA: begin
          if (cnt == STEP_LAST) begin
            state_next = PAUSA;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        GIRA: begin
          if (cnt == TURN_LAST) begin
            state_next = PAUSA;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        PAUSA: begin
          if (cnt == SETTLE_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      last_grant     <= GRANT_AUTO;
      motor_frente_q <= 1'b0;
      motor_giro_q   <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      last_grant     <= last_grant_next;
      motor_frente_q <= (state_next == AVANCA);
      motor_giro_q   <= (state_next == GIRA);
    end
  end

  assign bus.auto_passo   = tick;
  assign bus.man_gnt      = gnt && !reset;
  assign bus.motor_frente = motor_frente_q;
  assign bus.motor_giro   = motor_giro_q;
  assign bus.ocupado      = (state != IDLE);

endmodule

// File: tb/tb_robo_sequenciador.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based motion-plan model.
module tb_robo_sequenciador;

  localparam int TICK_DIV      = 2;
  localparam int STEP_CYCLES   = 4;
  localparam int TURN_CYCLES   = 8;
  localparam int SETTLE_CYCLES = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  robo_sequenciador_if bus ();

  robo_sequenciador #(
    .TICK_DIV      (TICK_DIV),
    .STEP_CYCLES   (STEP_CYCLES),
    .TURN_CYCLES   (TURN_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: a plan of {frente,giro} values, one entry per upcoming cycle; empty plan means idle.
  logic [1:0] plan[$];
  int         cycles_since_reset;
  bit         last_was_manual;
  bit         gnt_seen;

  function automatic bit model_tick();
    return !reset && ((cycles_since_reset % TICK_DIV) == TICK_DIV - 1);
  endfunction

  function automatic bit model_man_wins();
    return bus.man_req && !(last_was_manual && (bus.auto_avancar || bus.auto_girar));
  endfunction

  function automatic bit model_gnt();
    return !reset && !bus.parada && plan.size() == 0 && model_tick() && model_man_wins();
  endfunction

  function automatic logic [1:0] model_motors();
    return (plan.size() != 0) ? plan[0] : 2'b00;
  endfunction

  task automatic model_advance();
    bit t, av, gi;
    if (reset) begin
      plan.delete();
      cycles_since_reset = 0;
      last_was_manual    = 1'b0;
    end else begin
      t = model_tick();
      cycles_since_reset++;
      if (bus.parada) begin
        plan.delete();
      end else if (plan.size() != 0) begin
        void'(plan.pop_front());
      end else if (t) begin
        if (model_man_wins()) begin
          last_was_manual = 1'b1;
          gnt_seen        = 1'b1;
          av = bus.man_avancar;
          gi = bus.man_girar;
        end else begin
          last_was_manual = 1'b0;
          av = bus.auto_avancar;
          gi = bus.auto_girar;
        end
        if (gi) for (int i = 0; i < TURN_CYCLES; i++) plan.push_back(2'b01);
        else if (av) for (int i = 0; i < STEP_CYCLES; i++) plan.push_back(2'b10);
        if (gi || av) for (int i = 0; i < SETTLE_CYCLES; i++) plan.push_back(2'b00);
      end
    end
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares one cycle at the falling edge, then lets the model follow the rising edge.
  task automatic run_cycle();
    logic [1:0] m;
    @(negedge clock);
    m = model_motors();
    check("auto_passo",   bus.auto_passo,   model_tick());
    check("man_gnt",      bus.man_gnt,      model_gnt());
    check("motor_frente", bus.motor_frente, m[1]);
    check("motor_giro",   bus.motor_giro,   m[0]);
    check("ocupado",      bus.ocupado,      plan.size() != 0);
    check("motor_excl",   bus.motor_frente & bus.motor_giro, 1'b0);
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic set_inputs(input bit par, input bit aa, input bit ag,
                            input bit mr, input bit ma, input bit mg);
    bus.parada       = par;
    bus.auto_avancar = aa;
    bus.auto_girar   = ag;
    bus.man_req      = mr;
    bus.man_avancar  = ma;
    bus.man_girar    = mg;
  endtask

  initial begin
    bit found;
    set_inputs(0, 0, 0, 0, 0, 0);
    last_was_manual    = 1'b0;
    cycles_since_reset = 0;
    gnt_seen           = 1'b0;

    // Reset state, then free-running forward steps.
    repeat (2) @(posedge clock);
    model_advance();
    #1;
    set_inputs(0, 1, 0, 0, 0, 0);
    run_cycle();
    reset = 1'b0;
    repeat (30) run_cycle();

    // Turn takes precedence over forward.
    set_inputs(0, 1, 1, 0, 0, 0);
    repeat (30) run_cycle();

    // Manual turn request against an automatic forward request.
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    gnt_seen = 1'b0;
    set_inputs(0, 1, 0, 1, 0, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run_cycle();
      found = gnt_seen;
    end
    check("wait_man_gnt", found, 1'b1);
    set_inputs(0, 1, 0, 0, 0, 0);
    repeat (20) run_cycle();

    // Sustained contention alternates manual forward and automatic turn.
    set_inputs(0, 0, 1, 1, 1, 0);
    repeat (80) run_cycle();

    // Emergency stop on the third cycle of a turn with a manual request pending.
    set_inputs(0, 0, 1, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run_cycle();
      found = (plan.size() >= TURN_CYCLES + SETTLE_CYCLES);
    end
    check("wait_gira", found, 1'b1);
    repeat (2) run_cycle();
    set_inputs(1, 0, 1, 1, 1, 0);
    repeat (8) run_cycle();
    set_inputs(0, 0, 1, 1, 1, 0);
    repeat (12) run_cycle();

    // Reset on the second cycle of a forward step.
    set_inputs(0, 1, 0, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run_cycle();
      found = (plan.size() == STEP_CYCLES + SETTLE_CYCLES) && (plan[0] == 2'b10);
    end
    check("wait_avanca", found, 1'b1);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    repeat (8) run_cycle();

    // Random traffic with occasional stops and resets.
    for (int n = 0; n < 1500; n++) begin
      set_inputs(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
